// File: rtl/conv1_pkg.sv
// Shared constants and types for the conv1 post-accumulation stage.
package conv1_pkg;

  localparam int NUM_CH     = 64;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 16;
  localparam int FRAC_SHIFT = 8;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] act_t;
  typedef logic [5:0]              ch_idx_t;

endpackage

// File: rtl/conv1_round_sat.sv
// Combinational round-half-up shift, saturation and optional ReLU (CONV1_RELU_EN).
module conv1_round_sat
  import conv1_pkg::*;
(
  input  logic signed [ACC_W:0] sum,
  output act_t                  act
);

  localparam logic signed [ACC_W+1:0] RND     = (ACC_W+2)'(1) <<< (FRAC_SHIFT-1);
  localparam logic signed [ACC_W+1:0] SAT_MAX = (ACC_W+2)'((1 <<< (OUT_W-1)) - 1);
  localparam logic signed [ACC_W+1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W+1:0] ext;
  logic signed [ACC_W+1:0] r;

  // One guard bit above the 33-bit sum keeps the rounding add from overflowing.
  always_comb begin
    ext = {sum[ACC_W], sum};
    r   = (ext + RND) >>> FRAC_SHIFT;
    if (r > SAT_MAX) begin
      act = SAT_MAX[OUT_W-1:0];
    end else if (r < SAT_MIN) begin
      act = SAT_MIN[OUT_W-1:0];
    end else begin
      act = r[OUT_W-1:0];
    end
`ifdef CONV1_RELU_EN
    if (act[OUT_W-1]) begin
      act = '0;
    end
`endif
  end

endmodule

// File: rtl/conv1_bias_act.sv
// conv1 bias add + requantise + activation, two-stage pipeline with valid/ready.
// Activation rule selected by CONV1_RELU_EN (see conv1_round_sat).
module conv1_bias_act
  import conv1_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  acc_t    bias_mem [NUM_CH],
  input  acc_t    acc_data,
  input  logic    acc_valid,
  input  logic    acc_sof,
  output logic    acc_ready,
  output act_t    out_data,
  output ch_idx_t out_ch,
  output logic    out_last,
  output logic    out_valid,
  input  logic    out_ready,
  output logic    err_misalign
);

  logic                  adv;
  logic                  in_xfer;
  ch_idx_t               ch_cnt;
  ch_idx_t               beat_ch;
  ch_idx_t               ch_next;
  logic signed [ACC_W:0] sum_in;

  logic                  s1_valid;
  logic signed [ACC_W:0] s1_sum;
  ch_idx_t               s1_ch;
  act_t                  rs_out;

  // A start-of-frame beat is always channel 0, whatever the counter says.
  always_comb begin
    adv     = !out_valid || out_ready;
    in_xfer = acc_valid && adv;
    beat_ch = acc_sof ? '0 : ch_cnt;
    ch_next = (beat_ch == ch_idx_t'(NUM_CH-1)) ? '0 : beat_ch + 6'd1;
    sum_in  = {acc_data[ACC_W-1], acc_data} + {bias_mem[beat_ch][ACC_W-1], bias_mem[beat_ch]};
  end

  assign acc_ready = adv;

  conv1_round_sat u_round_sat (
    .sum (s1_sum),
    .act (rs_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt       <= '0;
      err_misalign <= 1'b0;
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      s1_ch        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
      out_last     <= 1'b0;
    end else begin
      if (in_xfer) begin
        ch_cnt <= ch_next;
        if (acc_sof && (ch_cnt != '0)) begin
          err_misalign <= 1'b1;
        end
      end
      // Both stages move together; a stalled output freezes the whole pipe.
      if (adv) begin
        s1_valid  <= in_xfer;
        s1_sum    <= sum_in;
        s1_ch     <= beat_ch;
        out_valid <= s1_valid;
        out_data  <= rs_out;
        out_ch    <= s1_ch;
        out_last  <= (s1_ch == ch_idx_t'(NUM_CH-1));
      end
    end
  end

endmodule

// File: tb/tb_conv1_bias_act.sv
// Directed self-checking bench for conv1_bias_act; expectations follow CONV1_RELU_EN.
module tb_conv1_bias_act;
  import conv1_pkg::*;

`ifdef CONV1_RELU_EN
  localparam logic signed [15:0] EXP_NEG25 = 16'sd0;
  localparam logic signed [15:0] EXP_MIN   = 16'sd0;
`else
  localparam logic signed [15:0] EXP_NEG25 = -16'sd25;
  localparam logic signed [15:0] EXP_MIN   = -16'sd32768;
`endif

  logic    clk = 1'b0;
  logic    rst;
  acc_t    bias_mem [NUM_CH];
  acc_t    acc_data;
  logic    acc_valid;
  logic    acc_sof;
  logic    acc_ready;
  act_t    out_data;
  ch_idx_t out_ch;
  logic    out_last;
  logic    out_valid;
  logic    out_ready;
  logic    err_misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv1_bias_act dut (
    .clk          (clk),
    .rst          (rst),
    .bias_mem     (bias_mem),
    .acc_data     (acc_data),
    .acc_valid    (acc_valid),
    .acc_sof      (acc_sof),
    .acc_ready    (acc_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_misalign (err_misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    acc_valid = 1'b0;
    acc_sof = 1'b0;
    acc_data = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin failures++; $display("[TB] FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (out_ch !== 6'd0) begin failures++; $display("[TB] FAIL reset_out_ch got=%0d exp=0", out_ch); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (err_misalign !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err_misalign); end
    checks++; if (acc_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_acc_ready got=%b exp=1", acc_ready); end
  endtask

  // Single ch0 beat after a fresh reset; checks 2-cycle latency and value.
  task automatic test_single(input string name, input acc_t data, input logic signed [15:0] exp);
    do_reset();
    acc_valid = 1'b1;
    acc_sof = 1'b1;
    acc_data = data;
    step();
    acc_valid = 1'b0;
    acc_sof = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s_early_valid got=%b exp=0", name, out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL %s_valid got=%b exp=1", name, out_valid); end
    checks++; if (out_data !== exp) begin failures++; $display("[TB] FAIL %s_data got=%0d exp=%0d", name, out_data, exp); end
    checks++; if (out_ch !== 6'd0) begin failures++; $display("[TB] FAIL %s_ch got=%0d exp=0", name, out_ch); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s_bubble got=%b exp=0", name, out_valid); end
  endtask

  task automatic test_ch7_neg_bias();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      acc_valid = 1'b1;
      acc_sof = (i == 0);
      acc_data = '0;
      step();
    end
    acc_valid = 1'b0;
    acc_sof = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ch7_valid got=%b exp=1", out_valid); end
    checks++; if (out_ch !== 6'd7) begin failures++; $display("[TB] FAIL ch7_ch got=%0d exp=7", out_ch); end
    checks++; if (out_data !== 16'sd0) begin failures++; $display("[TB] FAIL ch7_data got=%0d exp=0", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL ch7_last got=%b exp=0", out_last); end
  endtask

  // Beat i carries channel (i%64) with acc=ch*256; expected activation is ch, except ch0 -> 14.
  task automatic run_stream(input string name, input int n, input int stall_start, input int stall_len);
    int sent;
    int rcv;
    int cyc;
    int exp_ch;
    logic in_fire;
    logic out_fire;
    logic prev_hold;
    act_t held_data;
    ch_idx_t held_ch;
    logic signed [15:0] exp_data;
    sent = 0;
    rcv = 0;
    cyc = 0;
    prev_hold = 1'b0;
    held_data = '0;
    held_ch = '0;
    while (rcv < n && cyc < n + stall_len + 20) begin
      out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
      if (sent < n) begin
        acc_valid = 1'b1;
        acc_sof = ((sent % 64) == 0);
        acc_data = (sent % 64) * 256;
      end else begin
        acc_valid = 1'b0;
        acc_sof = 1'b0;
      end
      #1;
      in_fire = acc_valid && acc_ready;
      out_fire = out_valid && out_ready;
      if (out_valid && !out_ready) begin
        checks++; if (acc_ready !== 1'b0) begin failures++; $display("[TB] FAIL %s_stall_ready cyc=%0d got=%b exp=0", name, cyc, acc_ready); end
        if (prev_hold) begin
          checks++; if (out_data !== held_data) begin failures++; $display("[TB] FAIL %s_hold_data cyc=%0d got=%0d exp=%0d", name, cyc, out_data, held_data); end
          checks++; if (out_ch !== held_ch) begin failures++; $display("[TB] FAIL %s_hold_ch cyc=%0d got=%0d exp=%0d", name, cyc, out_ch, held_ch); end
        end
        prev_hold = 1'b1;
        held_data = out_data;
        held_ch = out_ch;
      end else begin
        prev_hold = 1'b0;
      end
      if (out_fire) begin
        exp_ch = rcv % 64;
        exp_data = (exp_ch == 0) ? 16'sd14 : 16'(exp_ch);
        checks++; if (out_ch !== 6'(exp_ch)) begin failures++; $display("[TB] FAIL %s_ch beat=%0d got=%0d exp=%0d", name, rcv, out_ch, exp_ch); end
        checks++; if (out_data !== exp_data) begin failures++; $display("[TB] FAIL %s_data beat=%0d got=%0d exp=%0d", name, rcv, out_data, exp_data); end
        checks++; if (out_last !== (exp_ch == 63)) begin failures++; $display("[TB] FAIL %s_last beat=%0d got=%b exp=%b", name, rcv, out_last, exp_ch == 63); end
        rcv++;
      end
      step();
      if (in_fire) sent++;
      cyc++;
    end
    checks++; if (rcv != n) begin failures++; $display("[TB] FAIL %s_count got=%0d exp=%0d", name, rcv, n); end
    acc_valid = 1'b0;
    acc_sof = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s_extra_out got=%b exp=0", name, out_valid); end
    checks++; if (err_misalign !== 1'b0) begin failures++; $display("[TB] FAIL %s_err got=%b exp=0", name, err_misalign); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_stream("b2b", 65, 1000, 0);
  endtask

  task automatic test_stall();
    do_reset();
    run_stream("stall", 20, 8, 5);
  endtask

  task automatic test_misalign_and_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      acc_valid = 1'b1;
      acc_sof = (i == 0) || (i == 9);
      acc_data = (i == 9) ? 32'sd256 : 32'sd0;
      step();
    end
    checks++; if (err_misalign !== 1'b1) begin failures++; $display("[TB] FAIL mis_err got=%b exp=1", err_misalign); end
    acc_sof = 1'b0;
    acc_data = 32'sd256;
    step();
    acc_valid = 1'b0;
    checks++; if (out_ch !== 6'd0) begin failures++; $display("[TB] FAIL mis_sof_ch got=%0d exp=0", out_ch); end
    checks++; if (out_data !== 16'sd15) begin failures++; $display("[TB] FAIL mis_sof_data got=%0d exp=15", out_data); end
    step();
    checks++; if (out_ch !== 6'd1) begin failures++; $display("[TB] FAIL mis_next_ch got=%0d exp=1", out_ch); end
    checks++; if (out_data !== 16'sd1) begin failures++; $display("[TB] FAIL mis_next_data got=%0d exp=1", out_data); end
    acc_valid = 1'b1;
    acc_data = 32'sd512;
    step();
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid got=%b exp=0", out_valid); end
    checks++; if (err_misalign !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_err got=%b exp=0", err_misalign); end
    rst = 1'b0;
    acc_sof = 1'b0;
    acc_data = 32'sd256;
    step();
    acc_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rst_after_valid got=%b exp=1", out_valid); end
    checks++; if (out_ch !== 6'd0) begin failures++; $display("[TB] FAIL rst_after_ch got=%0d exp=0", out_ch); end
    checks++; if (out_data !== 16'sd15) begin failures++; $display("[TB] FAIL rst_after_data got=%0d exp=15", out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_after_stray got=%b exp=0", out_valid); end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) bias_mem[c] = '0;
    bias_mem[0] = 32'sd3680;
    bias_mem[7] = -32'sd87;
    rst = 1'b1;
    acc_valid = 1'b0;
    acc_sof = 1'b0;
    acc_data = '0;
    out_ready = 1'b1;

    test_reset();
    test_single("round", 32'sd256, 16'sd15);
    test_single("neg", -32'sd10000, EXP_NEG25);
    test_single("sat_hi", 32'sh7FFF_FFFF, 16'sd32767);
    test_single("sat_lo", 32'sh8000_0000, EXP_MIN);
    test_ch7_neg_bias();
    test_back_to_back();
    test_stall();
    test_misalign_and_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv1_bias_act.md
Name: conv1_bias_act

Overview:
Post-accumulation stage for conv1, directly downstream of the conv1 MAC array and consumer of the 64-entry conv1 bias table (32-bit signed per output channel).
- Accepts one 32-bit signed accumulator word per output channel, in channel order 0..63 per output pixel.
- Adds that channel's bias, rounds and right-shifts to the activation scale, applies ReLU, saturates, and emits 16-bit activations to the conv1 output buffer.
- Two-stage pipeline with valid/ready backpressure.

Parameters:
- NUM_CH, 64, output channels per pixel; channel counter wraps at NUM_CH-1.
- ACC_W, 32, accumulator and bias width (signed).
- OUT_W, 16, output activation width (signed).
- FRAC_SHIFT, 8, arithmetic right shift from accumulator scale to activation scale; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- bias_mem  in  ACC_W x NUM_CH  per-channel bias array, constant during operation.
- acc_data  in  ACC_W  signed accumulator value.
- acc_valid  in  1  acc_data valid.
- acc_sof  in  1  qualifies acc_data as channel 0 of a new pixel.
- acc_ready  out  1  stage can accept this cycle.
- out_data  out  OUT_W  activation.
- out_ch  out  6  channel index of out_data.
- out_last  out  1  out_data is channel NUM_CH-1.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- err_misalign  out  1  sticky; set when acc_sof arrives with the channel counter != 0.

Behaviour:
Reset:
- rst forces out_valid=0, out_data=0, out_ch=0, out_last=0, err_misalign=0, channel counter=0, and both pipeline valids=0.
- Reset mid-pixel discards all in-flight data; there is no flush.

Handshake:
- Input transfer when acc_valid && acc_ready.
- Output transfer when out_valid && out_ready.
- out_data, out_ch and out_last hold stable while out_valid && !out_ready.
- Pipeline advance enable: adv = !out_valid || out_ready.
- acc_ready = adv; it is combinational from out_ready.

Channel counter:
- Increments on each input transfer and wraps NUM_CH-1 -> 0.
- On a transfer with acc_sof=1, the beat is channel 0 and the counter becomes 1.
- If acc_sof=1 with counter != 0, err_misalign sets (cleared only by rst) and the counter resyncs to 0.

Stage 1 (on adv):
- s1_sum = sext33(acc_data) + sext33(bias_mem[ch]).
- s1_ch = ch; s1_valid = input transfer.

Stage 2 (on adv):
- r = (sext34(s1_sum) + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. This is arithmetic shift, round-half-up (toward +inf on ties).
- Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Apply the activation rule (see Optional Feature).
- out_ch = s1_ch; out_last = (s1_ch == NUM_CH-1); out_valid = s1_valid.

Timing:
- Latency is 2 cycles from input transfer to out_valid when not stalled.
- Throughput is 1 per cycle.
- A bubble (acc_valid=0) propagates as out_valid=0.

Optional Feature:
- CONV1_RELU_EN defined: after the clamp, negative r becomes 0, so out_data lies in [0, 32767].
- CONV1_RELU_EN undefined: signed saturated output in [-32768, 32767] with no ReLU (linear layer / debug).

Decomposition:
- Package conv1_pkg holds:
  - NUM_CH, ACC_W, OUT_W, FRAC_SHIFT constants
  - typedef acc_t (logic signed [ACC_W-1:0])
  - typedef act_t (logic signed [OUT_W-1:0])
  - typedef ch_idx_t (logic [5:0])
- One sub-module, conv1_round_sat: purely combinational round/shift/clamp/ReLU from 33-bit sum to act_t.
- The top holds the counter, pipeline registers and handshake.

Test Plan:
- ch0 (bias 3680), acc=256, CONV1_RELU_EN -> out_data=15, out_ch=0, out_valid 2 cycles after accept.
- ch7 (bias -87), acc=0 -> sum=-87, r=0 -> out_data=0 (both builds). ch0, acc=-10000 -> r=-25 -> 0 with CONV1_RELU_EN, -25 without.
- ch0, acc=0x7FFFFFFF -> out_data=32767 (saturation, no wrap).
- 64 back-to-back beats, first with acc_sof, out_ready held at 1:
  - out_ch runs 0..63 with out_last only on 63.
  - The next acc_sof beat maps to ch0; err_misalign stays 0.
- out_ready=0 for 5 cycles mid-stream:
  - acc_ready drops the same cycle and out_data/out_ch hold.
  - No beat is lost or duplicated; order is preserved after release.
- acc_sof on the 10th beat of a pixel -> err_misalign=1 and that beat is processed as ch0. Then rst mid-stream -> out_valid=0 next cycle, err_misalign=0, counter=0.
